// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Optional PWM dimming is enabled by defining SSD_DIMMING_EN.
package ssd_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Wide all-ones constants, sliced down to the digit/segment width at use.
  localparam logic [31:0] SEG_OFF   = '1;
  localparam logic [31:0] ANODE_OFF = '1;

  function automatic int idx_w(input int num_digits);
    return (num_digits > 1) ? $clog2(num_digits) : 1;
  endfunction

endpackage

// File: rtl/ssd_refresh_timer.sv
// Slot timer: counts 0..DWELL_CYCLES-1 and strobes slot_wrap / blank_done.
module ssd_refresh_timer #(
  parameter int DWELL_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W        = $clog2(DWELL_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] slot_cnt,
  output logic             slot_wrap,
  output logic             blank_done
);

  logic [CNT_W-1:0] slot_cnt_q;
  logic [CNT_W-1:0] slot_cnt_d;

  always_comb begin
    slot_wrap  = (slot_cnt_q == CNT_W'(DWELL_CYCLES - 1));
    blank_done = (slot_cnt_q == CNT_W'(BLANK_CYCLES - 1));
    slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_q <= '0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
    end
  end

  assign slot_cnt = slot_cnt_q;

endmodule

// File: rtl/ssd_scan_ctrl.sv
// N-digit seven-segment scan controller with blanking, enable mask and frame-coherent latching.
// Define SSD_DIMMING_EN to add the brightness port and per-slot PWM dimming.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SEG_W        = 8,
  parameter int DWELL_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_DIGITS*SEG_W-1:0] digits,
  input  logic [NUM_DIGITS-1:0]       digit_en,
`ifdef SSD_DIMMING_EN
  input  logic [3:0]                  brightness,
`endif
  output logic [SEG_W-1:0]            cathode,
  output logic [NUM_DIGITS-1:0]       anode,
  output logic                        frame_start
);

  localparam int IDX_W = idx_w(NUM_DIGITS);
  localparam int CNT_W = $clog2(DWELL_CYCLES);

  logic [CNT_W-1:0] slot_cnt;
  logic             slot_wrap;
  logic             blank_done;

  scan_state_t                 state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [NUM_DIGITS*SEG_W-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]       anode_q, anode_d;
  logic [SEG_W-1:0]            cathode_q, cathode_d;
  logic                        frame_start_q, frame_start_d;
  logic                        pwm_on;

  ssd_refresh_timer #(
    .DWELL_CYCLES(DWELL_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .slot_cnt  (slot_cnt),
    .slot_wrap (slot_wrap),
    .blank_done(blank_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BLANK;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BLANK:   if (blank_done) state_d = DRIVE;
      DRIVE:   if (slot_wrap)  state_d = BLANK;
      default: state_d = BLANK;
    endcase
  end

`ifdef SSD_DIMMING_EN
  logic [3:0] pwm_cnt_q, pwm_cnt_d;

  // Cleared throughout BLANK so every DRIVE phase begins a fresh PWM window.
  always_comb begin
    pwm_cnt_d = (state_q == DRIVE) ? pwm_cnt_q + 4'd1 : 4'd0;
    pwm_on    = (pwm_cnt_q < brightness);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= 4'd0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end
`else
  always_comb pwm_on = 1'b1;
`endif

  // Snapshot taken on the first cycle of slot 0, so the whole frame is coherent.
  always_comb begin
    idx_d = idx_q;
    if (slot_wrap) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    frame_start_d = (slot_cnt == '0) && (idx_q == '0);
    shadow_d      = frame_start_d ? digits : shadow_q;
  end

  always_comb begin
    anode_d   = ANODE_OFF[NUM_DIGITS-1:0];
    cathode_d = SEG_OFF[SEG_W-1:0];
    if (state_q == DRIVE) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (IDX_W'(k) == idx_q) begin
          cathode_d  = shadow_q[k*SEG_W +: SEG_W];
          anode_d[k] = ~(digit_en[k] & pwm_on);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q         <= '0;
      shadow_q      <= '1;
      anode_q       <= ANODE_OFF[NUM_DIGITS-1:0];
      cathode_q     <= SEG_OFF[SEG_W-1:0];
      frame_start_q <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      anode_q       <= anode_d;
      cathode_q     <= cathode_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign anode       = anode_q;
  assign cathode     = cathode_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl (4 digits, 16-cycle slots, 4-cycle blank); SSD_DIMMING_EN adds PWM tests.
`timescale 1ns/1ps
module tb_ssd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] digits;
  logic [3:0]  digit_en;
`ifdef SSD_DIMMING_EN
  logic [3:0]  brightness;
`endif
  logic [7:0]  cathode;
  logic [3:0]  anode;
  logic        frame_start;

  int checks = 0;
  int errors = 0;
  int bright_m = 16;

  always #5 clk = ~clk;

  ssd_scan_ctrl #(
    .NUM_DIGITS  (4),
    .SEG_W       (8),
    .DWELL_CYCLES(16),
    .BLANK_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .digit_en   (digit_en),
`ifdef SSD_DIMMING_EN
    .brightness (brightness),
`endif
    .cathode    (cathode),
    .anode      (anode),
    .frame_start(frame_start)
  );

  // At most one anode may ever be low.
  always @(negedge clk) begin
    checks++;
    if ($countones(~anode) > 1) begin
      errors++;
      $display("FAIL one_hot_anode: anode=%b, required at most one low bit", anode);
    end
  end

  // Frame model: t=0 is the frame_start cycle; slot s covers t=16s..16s+15,
  // blank for the first 4 cycles, lit while (t%16-4) < bright_m.
  task automatic check_frame(input string name, input logic [3:0] en, input logic [31:0] snap,
                             input int chg_t, input logic [31:0] chg_val);
    logic [3:0]  exp_an;
    logic [7:0]  exp_ca;
    logic        exp_fs;
    logic [31:0] tmp;
    int          slot;
    int          rel;
    for (int t = 0; t < 64; t++) begin
      slot   = t / 16;
      rel    = (t % 16) - 4;
      exp_fs = (t == 0);
      exp_an = 4'hF;
      exp_ca = 8'hFF;
      if (rel >= 0) begin
        tmp    = snap >> (8 * slot);
        exp_ca = tmp[7:0];
        if (en[slot] && rel < bright_m) exp_an = 4'hF & ~(4'(1) << slot);
      end
      checks++;
      if (anode !== exp_an || cathode !== exp_ca || frame_start !== exp_fs) begin
        errors++;
        $display("FAIL %s t=%0d: anode=%b cathode=%h fs=%b, required anode=%b cathode=%h fs=%b",
                 name, t, anode, cathode, frame_start, exp_an, exp_ca, exp_fs);
      end
      if (t == chg_t) digits = chg_val;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (anode !== 4'hF || cathode !== 8'hFF || frame_start !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: anode=%b cathode=%h fs=%b, required 1111 ff 0",
                 anode, cathode, frame_start);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1 || anode !== 4'hF) begin
      errors++;
      $display("FAIL reset_first_fs: fs=%b anode=%b, required 1 1111", frame_start, anode);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (anode !== 4'hF || frame_start !== 1'b0) begin
        errors++;
        $display("FAIL reset_blank: anode=%b fs=%b, required 1111 0", anode, frame_start);
      end
    end
    @(negedge clk);
    checks++;
    if (anode !== 4'b1110 || cathode !== 8'hC0) begin
      errors++;
      $display("FAIL reset_first_drive: anode=%b cathode=%h, required 1110 c0", anode, cathode);
    end
    repeat (60) @(negedge clk);
  endtask

  task automatic test_scan();
    check_frame("scan", 4'hF, 32'hA4B0_99C0, -1, 32'h0);
  endtask

  task automatic test_mid_frame_update();
    check_frame("midframe_old", 4'hF, 32'hA4B0_99C0, 40, 32'h1234_5678);
    check_frame("midframe_new", 4'hF, 32'h1234_5678, -1, 32'h0);
  endtask

  task automatic test_digit_enable();
    digit_en = 4'b1011;
    check_frame("en_mask", 4'b1011, 32'h1234_5678, -1, 32'h0);
    digit_en = 4'hF;
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL en_frame_period: fs=%b, required 1 after 64 cycles", frame_start);
    end
  endtask

  task automatic test_reset_mid_scan();
    repeat (20) @(negedge clk);
    checks++;
    if (anode !== 4'b1101 || cathode !== 8'h56) begin
      errors++;
      $display("FAIL pre_reset_slot1: anode=%b cathode=%h, required 1101 56", anode, cathode);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (anode !== 4'hF || cathode !== 8'hFF || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: anode=%b cathode=%h fs=%b, required 1111 ff 0",
               anode, cathode, frame_start);
    end
    rst = 1'b0;
    @(negedge clk);
    check_frame("after_reset", 4'hF, 32'h1234_5678, -1, 32'h0);
  endtask

`ifdef SSD_DIMMING_EN
  task automatic test_dimming();
    brightness = 4'd4;
    bright_m   = 4;
    check_frame("dim4", 4'hF, 32'h1234_5678, -1, 32'h0);
    brightness = 4'd0;
    bright_m   = 0;
    check_frame("dim0", 4'hF, 32'h1234_5678, -1, 32'h0);
  endtask
`endif

  initial begin
    digits   = 32'hA4B0_99C0;
    digit_en = 4'hF;
`ifdef SSD_DIMMING_EN
    brightness = 4'd15;
    bright_m   = 15;
`endif
    test_reset();
    test_scan();
    test_mid_frame_update();
    test_digit_enable();
    test_reset_mid_scan();
`ifdef SSD_DIMMING_EN
    test_dimming();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
